gf_exp_sequencer: RTL

//  Multi-cycle GF(2^m) exponentiation controller: computes base^exp mod polyn by MSB-first square-and-multiply.

---
 rtl/gf_exp_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/gf_exp_sequencer.sv
// GF(2^m) square-and-multiply exponentiation controller driving a combinational clmul/reduce datapath.
// Optional GF_EXP_EARLY_EXIT_EN: start the scan at exp's highest set bit.
module gf_exp_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     base,
    input  logic [DATA_WIDTH-1:0]     exp,
    input  logic [DATA_WIDTH:0]       polyn,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      dp_sum_funct,
    output logic                      dp_exp_funct,
    output logic                      dp_red_funct,
    output logic                      dp_carry_option,
    output logic [DATA_WIDTH:0]       dp_polyn_red,
    output logic [2*DATA_WIDTH-1:0]   dp_reduc_in,
    output logic [DATA_WIDTH-1:0]     dp_a,
    output logic [DATA_WIDTH-1:0]     dp_b,
    input  logic [DATA_WIDTH-1:0]     dp_out,
    input  logic [2*DATA_WIDTH-1:0]   dp_mult_out
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        IDLE, SQR_MUL, SQR_RED, MUL_MUL, MUL_RED, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    base_q, base_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W:0]      polyn_q, polyn_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef GF_EXP_EARLY_EXIT_EN
    logic [IW-1:0]   msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (exp[i]) msb_idx = IW'(i);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        polyn_d  = polyn_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    polyn_d = polyn;
                    acc_d   = W'(1);
                    prod_d  = '0;
`ifdef GF_EXP_EARLY_EXIT_EN
                    if (exp == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = W'(1);
                        busy_d   = 1'b0;
                    end else begin
                        idx_d   = msb_idx;
                        state_d = SQR_MUL;
                        busy_d  = 1'b1;
                    end
`else
                    idx_d   = IW'(W - 1);
                    state_d = SQR_MUL;
                    busy_d  = 1'b1;
`endif
                end
            end
            SQR_MUL: begin
                prod_d  = dp_mult_out;
                state_d = SQR_RED;
            end
            SQR_RED: begin
                acc_d = dp_out;
                if (exp_q[idx_q]) begin
                    state_d = MUL_MUL;
                end else if (idx_q == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = dp_out;
                    busy_d   = 1'b0;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQR_MUL;
                end
            end
            MUL_MUL: begin
                prod_d  = dp_mult_out;
                state_d = MUL_RED;
            end
            MUL_RED: begin
                acc_d = dp_out;
                if (idx_q == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = dp_out;
                    busy_d   = 1'b0;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQR_MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            polyn_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            polyn_q  <= polyn_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Squaring is issued as a plain multiply with both operands equal to acc.
    always_comb begin
        dp_a         = '0;
        dp_b         = '0;
        dp_reduc_in  = '0;
        dp_red_funct = 1'b0;
        unique case (state_q)
            SQR_MUL: begin
                dp_a = acc_q;
                dp_b = acc_q;
            end
            MUL_MUL: begin
                dp_a = acc_q;
                dp_b = base_q;
            end
            SQR_RED, MUL_RED: begin
                dp_reduc_in  = prod_q;
                dp_red_funct = 1'b1;
            end
            default: begin
                dp_a = '0;
            end
        endcase
    end

    assign dp_sum_funct    = 1'b0;
    assign dp_exp_funct    = 1'b0;
    assign dp_carry_option = 1'b0;
    assign dp_polyn_red    = polyn_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign result          = result_q;

endmodule
